bnn_layer_sequencer: RTL and testbench
======================================

Name: bnn_layer_sequencer

Overview:
- Controller that sequences one shared Conv2d_MaxPool2d stage across NUM_LAYERS consecutive layers.
- Per layer it:
  - drives the stage's data_in_ready (level; low = clear);
  - selects the weight/input bank via layer_idx;
  - waits for the stage's data_out_ready;
  - pulses capture so the top level latches img_out into the next layer's input buffer.
- Sits between the top-level control (start, abort) and the downstream classifier (valid/ready result handshake).
- Includes a per-layer timeout watchdog.

Parameters:
- NUM_LAYERS, 2, number of conv/pool layers sequenced through the shared stage (>=1).
- TIMEOUT, 64, max RUN cycles allowed per layer before error (>=2).
- LIDX_W, $clog2(NUM_LAYERS) (min 1), width of layer_idx.
- CNT_W, $clog2(TIMEOUT+1), width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse/level; sampled only in IDLE, ERR or DONE-idle.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- stage_en  out  1  drives stage data_in_ready.
- stage_done  in  1  from stage data_out_ready.
- layer_idx  out  LIDX_W  active layer; selects weight bank and input buffer.
- capture  out  1  one-cycle pulse: latch stage img_out for layer_idx.
- busy  out  1  high in CLEAR, RUN, CAPTURE.
- run_cycles  out  CNT_W  RUN cycles used by the last completed layer.
- result_valid  out  1  final layer output available.
- result_ready  in  1  downstream accept.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, CLEAR, RUN, CAPTURE, OUT, ERR. Fully registered outputs, Moore style.
- Reset (rst_n low, async): state=IDLE. All outputs are 0: stage_en, layer_idx, capture, busy, run_cycles, result_valid, err_timeout. Counter = 0.
- IDLE:
  - start=1 at edge t → CLEAR at t+1 with layer_idx=0 and err_timeout cleared.
  - stage_done is ignored.
- CLEAR:
  - Exactly 1 cycle with stage_en=0, which forces the stage to reset its internal channel counter and outputs.
  - Then → RUN, with counter=0.
- RUN:
  - stage_en=1.
  - Each cycle with stage_done=0, counter increments.
  - stage_done=1 → CAPTURE, and run_cycles latches the counter value.
  - counter==TIMEOUT-1 with stage_done=0 → ERR.
  - If stage_done and the timeout condition occur in the same cycle, stage_done wins.
- CAPTURE:
  - capture=1 and stage_en=1 for exactly 1 cycle, so the stage outputs remain valid.
  - If layer_idx==NUM_LAYERS-1 → OUT.
  - Otherwise → CLEAR with layer_idx+1.
- OUT:
  - result_valid=1, stage_en=0, layer_idx held.
  - result_ready=1 → IDLE next cycle, result_valid=0.
  - result_valid must not drop without result_ready.
  - start is ignored.
- ERR:
  - err_timeout=1, stage_en=0, busy=0.
  - start → CLEAR (layer_idx=0, err_timeout=0).
  - Otherwise holds.
- abort:
  - Highest priority in any non-IDLE state: → IDLE next edge.
  - stage_en, capture, result_valid and busy are deasserted. err_timeout is cleared.
  - run_cycles is retained.
- Other rules:
  - start while busy or in OUT is ignored (no queuing).
  - stage_done while stage_en=0 is ignored (stale level from the previous layer).
  - layer_idx never exceeds NUM_LAYERS-1 and never wraps.
  - NUM_LAYERS=1: CAPTURE always goes to OUT.
- Latency:
  - For a stage asserting done after D RUN cycles: layer = 1 CLEAR + (D+1) RUN + 1 CAPTURE.
  - Total from start to result_valid = NUM_LAYERS*(D+3)+1 edges.

Test Plan:
- Reset mid-RUN (layer 1, counter 5), rst_n low → all outputs 0 immediately (async). After release, state IDLE and stage_en=0.
- Defaults, stage model asserting done 8 cycles after stage_en rises, result_ready=1:
  - start → capture pulses seen with layer_idx=0 then 1.
  - stage_en low exactly 1 cycle between layers.
  - result_valid asserted 23 edges after start.
  - run_cycles=8.
- result_ready held 0 for 5 cycles → result_valid stays 1 and layer_idx stays 1. Asserting ready → IDLE next cycle.
- Stage never asserts done:
  - err_timeout=1 after 64 RUN cycles on layer 0, stage_en=0.
  - A new start clears the flag and restarts at layer 0.
- stage_done first rises on the cycle counter==63 → CAPTURE, no error, run_cycles=63.
- abort asserted in CAPTURE of layer 0 → IDLE next edge, with no further capture and no result_valid. start during RUN is ignored (no restart of layer_idx).

Source files
------------

// File: rtl/bnn_layer_sequencer_if.sv
// Control/handshake bundle between the BNN layer sequencer, the shared
// conv/pool stage, top-level control and the downstream classifier.
interface bnn_layer_sequencer_if #(
    parameter int NUM_LAYERS = 2,
    parameter int TIMEOUT    = 64,
    parameter int LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    parameter int CNT_W      = $clog2(TIMEOUT + 1)
);
    logic              start;
    logic              abort;
    logic              stage_en;
    logic              stage_done;
    logic [LIDX_W-1:0] layer_idx;
    logic              capture;
    logic              busy;
    logic [CNT_W-1:0]  run_cycles;
    logic              result_valid;
    logic              result_ready;
    logic              err_timeout;

    modport master (
        input  start, abort, stage_done, result_ready,
        output stage_en, layer_idx, capture, busy, run_cycles,
               result_valid, err_timeout
    );

    modport slave (
        output start, abort, stage_done, result_ready,
        input  stage_en, layer_idx, capture, busy, run_cycles,
               result_valid, err_timeout
    );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Sequences one shared Conv2d_MaxPool2d stage across NUM_LAYERS layers:
// clear, run with a timeout watchdog, capture, then hand the result downstream.
module bnn_layer_sequencer #(
    parameter int NUM_LAYERS = 2,
    parameter int TIMEOUT    = 64,
    parameter int LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    parameter int CNT_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bnn_layer_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_OUT     = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [LIDX_W-1:0] layer_q, layer_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [CNT_W-1:0]  run_q, run_n;
    logic              err_q, err_n;

    logic              stage_en_q;
    logic              capture_q;
    logic              busy_q;
    logic              valid_q;

    always_comb begin
        state_n = state;
        layer_n = layer_q;
        cnt_n   = cnt_q;
        run_n   = run_q;
        err_n   = err_q;

        if (bus.abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            err_n   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_n = S_CLEAR;
                        layer_n = '0;
                        err_n   = 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end
                S_RUN: begin
                    // done takes precedence over a coincident watchdog expiry
                    if (bus.stage_done) begin
                        state_n = S_CAPTURE;
                        run_n   = cnt_q;
                    end else if (cnt_q == CNT_LIMIT) begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (layer_q == LAST_LAYER) begin
                        state_n = S_OUT;
                    end else begin
                        state_n = S_CLEAR;
                        layer_n = layer_q + LIDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (bus.result_ready) begin
                        state_n = S_IDLE;
                    end
                end
                S_ERR: begin
                    if (bus.start) begin
                        state_n = S_CLEAR;
                        layer_n = '0;
                        err_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Output flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            layer_q    <= '0;
            cnt_q      <= '0;
            run_q      <= '0;
            err_q      <= 1'b0;
            stage_en_q <= 1'b0;
            capture_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_n;
            layer_q    <= layer_n;
            cnt_q      <= cnt_n;
            run_q      <= run_n;
            err_q      <= err_n;
            stage_en_q <= (state_n == S_RUN) || (state_n == S_CAPTURE);
            capture_q  <= (state_n == S_CAPTURE);
            busy_q     <= (state_n == S_CLEAR) || (state_n == S_RUN) ||
                          (state_n == S_CAPTURE);
            valid_q    <= (state_n == S_OUT);
        end
    end

    assign bus.stage_en     = stage_en_q;
    assign bus.layer_idx    = layer_q;
    assign bus.capture      = capture_q;
    assign bus.busy         = busy_q;
    assign bus.run_cycles   = run_q;
    assign bus.result_valid = valid_q;
    assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer: a stage model raises done a set number
// of cycles after stage_en rises; expected captures are scoreboarded.
module tb_bnn_layer_sequencer;
    logic clk;
    logic rst_n;

    bnn_layer_sequencer_if #(.NUM_LAYERS(2), .TIMEOUT(64)) bus ();

    bnn_layer_sequencer #(.NUM_LAYERS(2), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage model: done rises done_after edges after stage_en rises (0 = never).
    int stage_cnt;
    int done_after;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_cnt      <= 0;
            bus.stage_done <= 1'b0;
        end else if (bus.stage_en) begin
            stage_cnt      <= stage_cnt + 1;
            bus.stage_done <= (done_after != 0) && (stage_cnt + 1 >= done_after);
        end else begin
            stage_cnt      <= 0;
            bus.stage_done <= 1'b0;
        end
    end

    typedef struct {
        int layer;
        int rc;
    } cap_t;
    cap_t exp_q[$];

    int nvec;
    int nfail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_cap(input int layer, input int rc);
        cap_t c;
        c.layer = layer;
        c.rc    = rc;
        exp_q.push_back(c);
    endtask

    // One clock, sampled 1 time unit after the edge; captures are scored here.
    task automatic tick();
        cap_t c;
        @(posedge clk);
        #1;
        if (bus.capture) begin
            if (exp_q.size() == 0) begin
                check("capture_unexpected", 32'(bus.capture), 32'd0);
            end else begin
                c = exp_q.pop_front();
                check("capture_layer", 32'(bus.layer_idx), 32'(c.layer));
                check("capture_run_cycles", 32'(bus.run_cycles), 32'(c.rc));
            end
        end
    endtask

    task automatic wait_valid(input string tag, input int limit, output int edges);
        edges = 0;
        while (!bus.result_valid && edges < limit) begin
            tick();
            edges++;
        end
        check(tag, 32'(bus.result_valid), 32'd1);
    endtask

    initial begin
        int n;
        int e;
        int clears;
        int gap;
        int max_gap;
        logic any_bad;

        nvec             = 0;
        nfail            = 0;
        done_after       = 8;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.result_ready = 1'b0;

        #12;
        check("rst_stage_en", 32'(bus.stage_en), 32'd0);
        check("rst_layer_idx", 32'(bus.layer_idx), 32'd0);
        check("rst_capture", 32'(bus.capture), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_run_cycles", 32'(bus.run_cycles), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // Nominal two-layer pass, D = 8, downstream always ready
        bus.result_ready = 1'b1;
        push_cap(0, 8);
        push_cap(1, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        check("t1_clear_stage_en", 32'(bus.stage_en), 32'd0);
        check("t1_clear_busy", 32'(bus.busy), 32'd1);
        check("t1_clear_layer", 32'(bus.layer_idx), 32'd0);
        clears  = 1;
        gap     = 1;
        max_gap = 1;
        while (!bus.result_valid && n < 100) begin
            tick();
            n++;
            if (bus.busy && !bus.stage_en) begin
                clears++;
                gap++;
                if (gap > max_gap) max_gap = gap;
            end else begin
                gap = 0;
            end
        end
        check("t1_valid_latency", 32'(n), 32'd23);
        check("t1_clear_cycles", 32'(clears), 32'd2);
        check("t1_clear_gap", 32'(max_gap), 32'd1);
        check("t1_run_cycles", 32'(bus.run_cycles), 32'd8);
        check("t1_out_layer", 32'(bus.layer_idx), 32'd1);
        check("t1_out_stage_en", 32'(bus.stage_en), 32'd0);
        check("t1_caps_done", 32'(exp_q.size()), 32'd0);
        tick();
        check("t1_idle_valid", 32'(bus.result_valid), 32'd0);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        // Downstream back-pressure; start during OUT must be ignored
        bus.result_ready = 1'b0;
        push_cap(0, 8);
        push_cap(1, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid("t2_valid_seen", 60, e);
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(bus.result_valid), 32'd1);
            check("t2_hold_layer", 32'(bus.layer_idx), 32'd1);
        end
        bus.start        = 1'b0;
        bus.result_ready = 1'b1;
        tick();
        check("t2_release_valid", 32'(bus.result_valid), 32'd0);
        check("t2_release_busy", 32'(bus.busy), 32'd0);
        tick();
        check("t2_idle_busy", 32'(bus.busy), 32'd0);

        // Stage never finishes: watchdog fires after 64 RUN cycles
        done_after = 0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.err_timeout && n < 200) begin
            tick();
            n++;
        end
        check("t3_err_latency", 32'(n), 32'd66);
        check("t3_err_flag", 32'(bus.err_timeout), 32'd1);
        check("t3_err_stage_en", 32'(bus.stage_en), 32'd0);
        check("t3_err_busy", 32'(bus.busy), 32'd0);
        check("t3_err_layer", 32'(bus.layer_idx), 32'd0);
        tick();
        tick();
        check("t3_err_sticky", 32'(bus.err_timeout), 32'd1);
        done_after = 8;
        push_cap(0, 8);
        push_cap(1, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t3_restart_err", 32'(bus.err_timeout), 32'd0);
        check("t3_restart_layer", 32'(bus.layer_idx), 32'd0);
        check("t3_restart_busy", 32'(bus.busy), 32'd1);
        wait_valid("t3_valid_seen", 60, e);
        check("t3_valid_latency", 32'(e + 1), 32'd23);
        tick();

        // Done coincides with the last allowed RUN cycle: done wins
        done_after = 63;
        push_cap(0, 63);
        push_cap(1, 63);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid("t4_valid_seen", 300, e);
        check("t4_valid_latency", 32'(e + 1), 32'd133);
        check("t4_no_err", 32'(bus.err_timeout), 32'd0);
        check("t4_run_cycles", 32'(bus.run_cycles), 32'd63);
        tick();

        // Start during RUN ignored; abort in CAPTURE of layer 0
        done_after = 8;
        push_cap(0, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        check("t5_run_layer", 32'(bus.layer_idx), 32'd0);
        check("t5_run_stage_en", 32'(bus.stage_en), 32'd1);
        n = 0;
        while (!bus.capture && n < 50) begin
            tick();
            n++;
        end
        check("t5_capture_seen", 32'(bus.capture), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_abort_busy", 32'(bus.busy), 32'd0);
        check("t5_abort_stage_en", 32'(bus.stage_en), 32'd0);
        check("t5_abort_capture", 32'(bus.capture), 32'd0);
        check("t5_abort_valid", 32'(bus.result_valid), 32'd0);
        check("t5_abort_run_cycles", 32'(bus.run_cycles), 32'd8);
        any_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.result_valid || bus.busy || bus.stage_en) any_bad = 1'b1;
        end
        check("t5_stays_idle", 32'(any_bad), 32'd0);

        // Asynchronous reset in layer 1 RUN with counter at 5
        push_cap(0, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("t6_pre_layer", 32'(bus.layer_idx), 32'd1);
        check("t6_pre_stage_en", 32'(bus.stage_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_stage_en", 32'(bus.stage_en), 32'd0);
        check("t6_rst_layer_idx", 32'(bus.layer_idx), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_run_cycles", 32'(bus.run_cycles), 32'd0);
        check("t6_rst_capture", 32'(bus.capture), 32'd0);
        check("t6_rst_valid", 32'(bus.result_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("t6_idle_stage_en", 32'(bus.stage_en), 32'd0);
        check("t6_idle_busy", 32'(bus.busy), 32'd0);
        check("t6_caps_done", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
